// File: rtl/acc4_lane_accumulator.sv
// acc4_lane_accumulator: accumulates four lane sums over a packet and presents the totals on valid/ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous abort of packet in progress and held result
//   in_valid/in_ready   beat handshake; in_last closes the packet
//   in_sum1..4          lane sums (DATA_WIDTH)
//   out_valid/out_ready result handshake
//   out_acc1..4         lane totals (ACC_WIDTH); out_beats beat count; out_ovf per-lane sticky carry
module acc4_lane_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_sum1,
  input  logic [DATA_WIDTH-1:0] in_sum2,
  input  logic [DATA_WIDTH-1:0] in_sum3,
  input  logic [DATA_WIDTH-1:0] in_sum4,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_acc1,
  output logic [ACC_WIDTH-1:0]  out_acc2,
  output logic [ACC_WIDTH-1:0]  out_acc3,
  output logic [ACC_WIDTH-1:0]  out_acc4,
  output logic [CNT_WIDTH-1:0]  out_beats,
  output logic [3:0]            out_ovf
);
  localparam int AW1 = ACC_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nxt;
  logic beat, first;
  logic [3:0][DATA_WIDTH-1:0] din;
  logic [3:0][ACC_WIDTH-1:0] acc, acc_nxt, res;
  logic [3:0][AW1-1:0] sum;
  logic [3:0] ovf, ovf_nxt, res_ovf;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, res_cnt;
  assign din = {in_sum4, in_sum3, in_sum2, in_sum1};
  assign beat = in_valid && in_ready;
  // IDLE means the next beat opens a packet, so it loads instead of adding
  assign first = state == IDLE;
  assign cnt_nxt = first ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sum[k] = (first ? AW1'(0) : AW1'(acc[k])) + AW1'(din[k]);
      acc_nxt[k] = sum[k][ACC_WIDTH-1:0];
      ovf_nxt[k] = (!first && ovf[k]) || sum[k][ACC_WIDTH];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = clear ? IDLE :
                state == HOLD ? (out_ready ? IDLE : HOLD) :
                beat ? (in_last ? HOLD : ACCUM) : state;
  always_comb begin
    in_ready = state != HOLD;
    out_valid = state == HOLD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= '0;
      cnt <= '0;
      res <= '0;
      res_ovf <= '0;
      res_cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      ovf <= '0;
      cnt <= '0;
    end else if (beat) begin
      acc <= acc_nxt;
      ovf <= ovf_nxt;
      cnt <= cnt_nxt;
      if (in_last) begin
        res <= acc_nxt;
        res_ovf <= ovf_nxt;
        res_cnt <= cnt_nxt;
      end
    end
  end
  assign out_acc1 = res[0];
  assign out_acc2 = res[1];
  assign out_acc3 = res[2];
  assign out_acc4 = res[3];
  assign out_beats = res_cnt;
  assign out_ovf = res_ovf;
endmodule

// File: tb/tb_acc4_lane_accumulator.sv
// tb_acc4_lane_accumulator: directed table and sequence checks for acc4_lane_accumulator.
module tb_acc4_lane_accumulator;
  logic clk = 0, rst_n = 1, clear = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_sum1 = 0, in_sum2 = 0, in_sum3 = 0, in_sum4 = 0;
  logic in_ready, out_valid, r16, v16;
  logic [23:0] out_acc1, out_acc2, out_acc3, out_acc4;
  logic [15:0] a16_1, a16_2, a16_3, a16_4;
  logic [7:0] out_beats, b16;
  logic [3:0] out_ovf, o16;
  int checks = 0, errors = 0;

  acc4_lane_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_sum1(in_sum1), .in_sum2(in_sum2), .in_sum3(in_sum3), .in_sum4(in_sum4),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc1(out_acc1), .out_acc2(out_acc2),
    .out_acc3(out_acc3), .out_acc4(out_acc4), .out_beats(out_beats), .out_ovf(out_ovf));

  acc4_lane_accumulator #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(r16),
    .in_last(in_last), .in_sum1(in_sum1), .in_sum2(in_sum2), .in_sum3(in_sum3), .in_sum4(in_sum4),
    .out_valid(v16), .out_ready(out_ready), .out_acc1(a16_1), .out_acc2(a16_2),
    .out_acc3(a16_3), .out_acc4(a16_4), .out_beats(b16), .out_ovf(o16));

  always #5 clk = ~clk;

  typedef struct {
    logic v, l, r;
    logic [3:0][15:0] s;
    logic ev, er;
    logic [3:0][23:0] e;
    logic [7:0] eb;
    logic [3:0] eo;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(logic v, l, r, logic [3:0][15:0] s, logic ev, er,
                              logic [3:0][23:0] e, logic [7:0] eb, logic [3:0] eo);
    vec_t t;
    t.v = v; t.l = l; t.r = r; t.s = s; t.ev = ev; t.er = er; t.e = e; t.eb = eb; t.eo = eo;
    return t;
  endfunction

  function automatic logic [3:0][15:0] u16(logic [15:0] x);
    return {x, x, x, x};
  endfunction

  function automatic logic [3:0][23:0] u24(logic [23:0] x);
    return {x, x, x, x};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic l, input logic [3:0][15:0] s);
    in_valid = v; in_last = l;
    {in_sum4, in_sum3, in_sum2, in_sum1} = s;
  endtask

  task automatic chk_res(input string n, input logic [3:0][23:0] e, input logic [7:0] eb,
                         input logic [3:0] eo);
    chk({n, " acc1"}, 32'(out_acc1), 32'(e[0]));
    chk({n, " acc2"}, 32'(out_acc2), 32'(e[1]));
    chk({n, " acc3"}, 32'(out_acc3), 32'(e[2]));
    chk({n, " acc4"}, 32'(out_acc4), 32'(e[3]));
    chk({n, " beats"}, 32'(out_beats), 32'(eb));
    chk({n, " ovf"}, 32'(out_ovf), 32'(eo));
  endtask

  initial begin
    // single beat, held one extra cycle, released
    vq.push_back(mk(1, 1, 0, {16'd4, 16'd3, 16'd2, 16'd1}, 1, 0, {24'd4, 24'd3, 24'd2, 24'd1}, 1, 0));
    vq.push_back(mk(0, 0, 0, u16(0), 1, 0, {24'd4, 24'd3, 24'd2, 24'd1}, 1, 0));
    vq.push_back(mk(0, 0, 1, u16(0), 0, 1, u24(0), 0, 0));
    // three beats of 0xFFFF, then five backpressured cycles with a beat offered that must be ignored
    vq.push_back(mk(1, 0, 0, u16(16'hFFFF), 0, 1, u24(0), 0, 0));
    vq.push_back(mk(1, 0, 0, u16(16'hFFFF), 0, 1, u24(0), 0, 0));
    vq.push_back(mk(1, 1, 0, u16(16'hFFFF), 1, 0, u24(24'h2FFFD), 3, 0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1, 0, 0, u16(16'h1111), 1, 0, u24(24'h2FFFD), 3, 0));
    vq.push_back(mk(0, 0, 1, u16(0), 0, 1, u24(0), 0, 0));
    // back-to-back with out_ready high; the source holds each beat until accepted
    vq.push_back(mk(1, 0, 1, {16'd40, 16'd30, 16'd20, 16'd10}, 0, 1, u24(0), 0, 0));
    vq.push_back(mk(1, 1, 1, u16(1), 1, 0, {24'd41, 24'd31, 24'd21, 24'd11}, 2, 0));
    vq.push_back(mk(1, 1, 1, u16(7), 0, 1, u24(0), 0, 0));
    vq.push_back(mk(1, 1, 1, u16(7), 1, 0, u24(7), 1, 0));
    vq.push_back(mk(1, 0, 1, u16(2), 0, 1, u24(0), 0, 0));
    vq.push_back(mk(1, 0, 1, u16(2), 0, 1, u24(0), 0, 0));
    vq.push_back(mk(1, 1, 1, u16(3), 1, 0, u24(5), 2, 0));
    vq.push_back(mk(0, 0, 1, u16(0), 0, 1, u24(0), 0, 0));

    // asynchronous reset asserted mid-cycle
    #3 rst_n = 0;
    #1;
    chk("reset valid", 32'(out_valid), 0);
    chk_res("reset", u24(0), 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset in_ready", 32'(in_ready), 1);
    @(negedge clk);

    foreach (vq[i]) begin
      beat(vq[i].v, vq[i].l, vq[i].s);
      out_ready = vq[i].r;
      tick();
      chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(vq[i].ev));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vq[i].er));
      if (vq[i].ev) chk_res($sformatf("v%0d", i), vq[i].e, vq[i].eb, vq[i].eo);
    end

    // lane 1 overflow in the 16-bit build
    out_ready = 0;
    beat(1, 0, {16'd0, 16'd0, 16'd0, 16'hFFFF});
    tick();
    beat(1, 1, {16'd0, 16'd0, 16'd0, 16'h0002});
    tick();
    beat(0, 0, u16(0));
    chk("ovf16 valid", 32'(v16), 1);
    chk("ovf16 acc1", 32'(a16_1), 32'h0001);
    chk("ovf16 ovf", 32'(o16), 32'b0001);
    chk("ovf16 beats", 32'(b16), 2);
    chk("ovf24 acc1", 32'(out_acc1), 32'h10001);
    chk("ovf24 ovf", 32'(out_ovf), 0);
    out_ready = 1;
    tick();
    beat(1, 1, {16'd0, 16'd0, 16'd0, 16'd3});
    tick();
    beat(0, 0, u16(0));
    chk("ovf16 next acc1", 32'(a16_1), 3);
    chk("ovf16 next ovf", 32'(o16), 0);
    chk("ovf16 next in_ready", 32'(r16), 0);
    tick();

    // clear in ACCUM with a simultaneous beat
    out_ready = 0;
    beat(1, 0, u16(9));
    tick();
    clear = 1;
    beat(1, 1, u16(100));
    tick();
    clear = 0;
    chk("clr accum valid", 32'(out_valid), 0);
    chk("clr accum in_ready", 32'(in_ready), 1);
    beat(1, 1, u16(5));
    tick();
    beat(0, 0, u16(0));
    chk("clr next valid", 32'(out_valid), 1);
    chk_res("clr next", u24(5), 1, 0);
    // clear in HOLD
    clear = 1;
    tick();
    clear = 0;
    chk("clr hold valid", 32'(out_valid), 0);
    chk("clr hold in_ready", 32'(in_ready), 1);
    // clear in IDLE drops a single-beat packet
    clear = 1;
    beat(1, 1, u16(8));
    tick();
    clear = 0;
    beat(0, 0, u16(0));
    tick();
    chk("clr idle valid", 32'(out_valid), 0);

    // reset mid-packet
    beat(1, 0, u16(4));
    tick();
    beat(0, 0, u16(0));
    #2 rst_n = 0;
    #1;
    chk("midrst valid", 32'(out_valid), 0);
    chk_res("midrst", u24(0), 0, 0);
    @(negedge clk);
    rst_n = 1;
    beat(1, 1, u16(6));
    tick();
    beat(0, 0, u16(0));
    chk("midrst next valid", 32'(out_valid), 1);
    chk_res("midrst next", u24(6), 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
